// File: rtl/ray_pixel_scheduler.sv
// Raster-order pixel coordinate issuer with credit-bounded in-flight count and retire-address FIFO.
// First beat 2 cycles after start; beats hold under tready backpressure, issue pauses at MAX_INFLIGHT credits.
module ray_pixel_scheduler #(
  parameter int H_PIXELS     = 320,
  parameter int V_PIXELS     = 180,
  parameter int HW           = 9,
  parameter int VW           = 8,
  parameter int MAX_INFLIGHT = 32,
  parameter int AW           = 17
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              start,
  output logic                              busy,
  output logic                              frame_done,
  output logic [HW+VW-1:0]                  coord_axis_tdata,
  output logic                              coord_axis_tvalid,
  input  logic                              coord_axis_tready,
  input  logic                              retire_valid,
  input  logic                              retire_ready,
  output logic [AW-1:0]                     retire_addr,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              underflow_err
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  typedef struct packed {
    logic [VW-1:0] v;
    logic [HW-1:0] h;
  } coord_t;

  state_t        r_state;
  coord_t        r_coord;
  logic [AW-1:0] r_addr;
  logic          r_tvalid;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_underflow;
  logic [CW-1:0] r_inflight;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [AW-1:0] r_mem [MAX_INFLIGHT];

  logic          w_coord_hs;
  logic          w_retire_hs;
  logic          w_fifo_empty;
  logic          w_pop;
  logic          w_last_h;
  logic          w_last_pix;
  logic [CW-1:0] w_inflight_nxt;

  assign w_coord_hs     = r_tvalid && coord_axis_tready;
  assign w_retire_hs    = retire_valid && retire_ready;
  // The in-flight count doubles as the address FIFO occupancy.
  assign w_fifo_empty   = (r_inflight == '0);
  assign w_pop          = w_retire_hs && !w_fifo_empty;
  assign w_last_h       = (r_coord.h == HW'(H_PIXELS - 1));
  assign w_last_pix     = w_last_h && (r_coord.v == VW'(V_PIXELS - 1));
  assign w_inflight_nxt = r_inflight + CW'(w_coord_hs) - CW'(w_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_coord      <= '0;
      r_addr       <= '0;
      r_tvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_inflight   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_inflight   <= w_inflight_nxt;
      if (w_retire_hs && w_fifo_empty) r_underflow <= 1'b1;
      if (w_coord_hs) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      case (r_state)
        S_IDLE: begin
          // A start coinciding with the frame_done pulse is dropped.
          if (start && !r_frame_done) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            r_coord <= '0;
            r_addr  <= '0;
          end
        end
        S_ISSUE: begin
          if (w_coord_hs) begin
            if (w_last_pix) begin
              r_state  <= S_DRAIN;
              r_tvalid <= 1'b0;
              r_coord  <= '0;
              r_addr   <= '0;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (w_last_h) begin
                r_coord.h <= '0;
                r_coord.v <= r_coord.v + 1'b1;
              end else begin
                r_coord.h <= r_coord.h + 1'b1;
              end
              r_tvalid <= (w_inflight_nxt < CW'(MAX_INFLIGHT));
            end
          end else if (!r_tvalid && (r_inflight < CW'(MAX_INFLIGHT))) begin
            r_tvalid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if ((r_inflight == '0) && !w_retire_hs) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_coord_hs) r_mem[r_wr_ptr] <= r_addr;
  end

  assign busy              = r_busy;
  assign frame_done        = r_frame_done;
  assign coord_axis_tdata  = r_coord;
  assign coord_axis_tvalid = r_tvalid;
  assign retire_addr       = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
  assign inflight          = r_inflight;
  assign underflow_err     = r_underflow;
endmodule

// File: tb/tb_ray_pixel_scheduler.sv
// Directed bench for ray_pixel_scheduler: a 4x2 frame on a wide-credit instance and a 4-credit instance.
module tb_ray_pixel_scheduler;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int HW = 2;
  localparam int VW = 1;
  localparam int AW = 3;
  localparam int MA = 32;
  localparam int MB = 4;
  localparam int CA = $clog2(MA + 1);
  localparam int CB = $clog2(MB + 1);

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic              start_a, busy_a, fd_a, tvalid_a, tready_a, rv_a, rr_a, uf_a;
  logic [HW+VW-1:0]  tdata_a;
  logic [AW-1:0]     raddr_a;
  logic [CA-1:0]     infl_a;
  logic              start_b, busy_b, fd_b, tvalid_b, tready_b, rv_b, rr_b, uf_b;
  logic [HW+VW-1:0]  tdata_b;
  logic [AW-1:0]     raddr_b;
  logic [CB-1:0]     infl_b;

  ray_pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .HW(HW), .VW(VW), .MAX_INFLIGHT(MA), .AW(AW)) u_a (
    .aclk(aclk), .aresetn(aresetn), .start(start_a), .busy(busy_a), .frame_done(fd_a),
    .coord_axis_tdata(tdata_a), .coord_axis_tvalid(tvalid_a), .coord_axis_tready(tready_a),
    .retire_valid(rv_a), .retire_ready(rr_a), .retire_addr(raddr_a), .inflight(infl_a),
    .underflow_err(uf_a));

  ray_pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .HW(HW), .VW(VW), .MAX_INFLIGHT(MB), .AW(AW)) u_b (
    .aclk(aclk), .aresetn(aresetn), .start(start_b), .busy(busy_b), .frame_done(fd_b),
    .coord_axis_tdata(tdata_b), .coord_axis_tvalid(tvalid_b), .coord_axis_tready(tready_b),
    .retire_valid(rv_b), .retire_ready(rr_b), .retire_addr(raddr_b), .inflight(infl_b),
    .underflow_err(uf_b));

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] dl_a = '0;
  bit auto_a = 1'b0;
  int cyc, beats, rets, fds, hs_b, outs, ret_b, fdb;
  bit held;
  logic [31:0] held_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_coord(input int k);
    return 32'(((k / H) << HW) | (k % H));
  endfunction

  // One clock; instance A's retire stream echoes each coordinate handshake 17 cycles later.
  task automatic step();
    logic hs;
    hs = tvalid_a && tready_a;
    @(posedge aclk);
    #1;
    dl_a = {dl_a[15:0], hs};
    if (auto_a) rv_a = dl_a[16];
  endtask

  initial begin
    start_a = 0; tready_a = 1; rv_a = 0; rr_a = 1;
    start_b = 0; tready_b = 1; rv_b = 0; rr_b = 1;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_tvalid", tvalid_a, 0);
    chk("rst_tdata", tdata_a, 0);
    chk("rst_inflight", infl_a, 0);
    chk("rst_retire_addr", raddr_a, 0);
    chk("rst_underflow", uf_a, 0);
    chk("rst_b_tvalid", tvalid_b, 0);
    chk("rst_b_inflight", infl_b, 0);
    aresetn = 1;
    step();

    // Full frame, tready high, retires 17 cycles after issue.
    start_a = 1; step(); start_a = 0;
    chk("t1_busy_c1", busy_a, 1);
    chk("t1_tvalid_c1", tvalid_a, 0);
    auto_a = 1;
    cyc = 1; beats = 0; rets = 0; fds = 0;
    for (int i = 0; i < 45; i++) begin
      if (tvalid_a && tready_a) begin
        chk("t1_beat_cycle", cyc, beats + 2);
        chk("t1_beat_data", tdata_a, exp_coord(beats));
        beats++;
      end
      if (rv_a && rr_a) begin
        chk("t1_retire_addr", raddr_a, rets);
        rets++;
      end
      if (fd_a) begin
        fds++;
        chk("t1_fd_after_last_retire", rets, 8);
        chk("t1_busy_at_fd", busy_a, 0);
      end
      step();
      cyc++;
    end
    chk("t1_beats", beats, 8);
    chk("t1_retires", rets, 8);
    chk("t1_frame_done_count", fds, 1);
    chk("t1_busy_end", busy_a, 0);
    chk("t1_inflight_end", infl_a, 0);
    chk("t1_underflow_end", uf_a, 0);

    // Pseudo-random tready: beats must hold until accepted.
    tready_a = 0;
    start_a = 1; step(); start_a = 0;
    beats = 0; rets = 0; fds = 0; held = 0; held_dat = 0;
    for (int i = 0; i < 150; i++) begin
      if (held) begin
        chk("t3_hold_valid", tvalid_a, 1);
        chk("t3_hold_data", tdata_a, held_dat);
      end
      tready_a = 1'($urandom_range(0, 1));
      if (tvalid_a && tready_a) begin
        chk("t3_beat_data", tdata_a, exp_coord(beats));
        beats++;
      end
      if (rv_a && rr_a) begin
        chk("t3_retire_addr", raddr_a, rets);
        rets++;
      end
      if (fd_a) fds++;
      held = tvalid_a && !tready_a;
      held_dat = 32'(tdata_a);
      step();
    end
    tready_a = 1;
    chk("t3_beats", beats, 8);
    chk("t3_retires", rets, 8);
    chk("t3_frame_done_count", fds, 1);
    chk("t3_busy_end", busy_a, 0);

    // Retire while idle with an empty FIFO.
    auto_a = 0;
    rv_a = 1; step(); rv_a = 0;
    chk("t5_underflow_set", uf_a, 1);
    chk("t5_inflight_zero", infl_a, 0);
    repeat (5) step();
    chk("t5_underflow_sticky", uf_a, 1);
    chk("t5_busy", busy_a, 0);

    // Asynchronous reset mid-frame with a beat held.
    start_a = 1; step(); start_a = 0;
    step(); step(); step();
    tready_a = 0;
    step();
    chk("t6_pre_tvalid", tvalid_a, 1);
    chk("t6_pre_inflight", infl_a, 2);
    #2 aresetn = 0;
    #1;
    chk("t6_rst_tvalid", tvalid_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_inflight", infl_a, 0);
    chk("t6_rst_underflow", uf_a, 0);
    chk("t6_rst_tdata", tdata_a, 0);
    #3 aresetn = 1;
    step();
    tready_a = 1;
    start_a = 1; step(); start_a = 0;
    step();
    chk("t6_restart_tvalid", tvalid_a, 1);
    chk("t6_restart_tdata", tdata_a, 0);
    step();
    chk("t6_restart_inflight", infl_a, 1);
    chk("t6_restart_addr", raddr_a, 0);
    chk("t6_restart_next", tdata_a, exp_coord(1));

    // Credit limit on the 4-credit instance, retire held low.
    start_b = 1; step(); start_b = 0;
    hs_b = 0;
    for (int i = 0; i < 12; i++) begin
      if (tvalid_b && tready_b) hs_b++;
      step();
    end
    chk("t2_accepted", hs_b, 4);
    chk("t2_tvalid_low", tvalid_b, 0);
    chk("t2_inflight_full", infl_b, 4);
    chk("t2_busy", busy_b, 1);
    chk("t2_head", raddr_b, 0);
    rv_b = 1; step(); rv_b = 0;
    chk("t2_inflight_after_retire", infl_b, 3);
    chk("t2_tvalid_still_low", tvalid_b, 0);
    chk("t2_head_after_retire", raddr_b, 1);
    step();
    chk("t2_tvalid_raised", tvalid_b, 1);
    chk("t2_next_beat", tdata_b, exp_coord(4));

    // Coordinate and retire handshakes together at MAX-1.
    rv_b = 1; step(); rv_b = 0;
    chk("t4_inflight_same", infl_b, 3);
    chk("t4_head_advanced", raddr_b, 2);
    chk("t4_tvalid", tvalid_b, 1);
    chk("t4_next_beat", tdata_b, exp_coord(5));

    ret_b = 2; fdb = 0; outs = 3;
    for (int i = 0; i < 40; i++) begin
      rv_b = (outs > 0);
      if (rv_b) begin
        chk("t4_drain_addr", raddr_b, ret_b);
        ret_b++;
      end
      outs = outs + ((tvalid_b && tready_b) ? 1 : 0) - (rv_b ? 1 : 0);
      if (fd_b) fdb++;
      step();
    end
    rv_b = 0;
    chk("t4_retires", ret_b, 8);
    chk("t4_frame_done_count", fdb, 1);
    chk("t4_busy_end", busy_b, 0);
    chk("t4_inflight_end", infl_b, 0);
    chk("t4_underflow", uf_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
